// File: rtl/risc_mem_pkg.sv
// Shared types and address helpers for the RISC memory subsystem.
package risc_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  localparam int BYTE_W = 8;

  // Addresses are zero-extended to 64 bits so one helper serves any WIDTH <= 64.
  function automatic logic [63:0] word_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic in_range(input logic [63:0] addr, input int idx_w);
    return (addr >> (idx_w + 2)) == 64'd0;
  endfunction

endpackage

// File: rtl/risc_mem_port.sv
// One request/valid port: handshake FSM, wait-state counter and response registers.
module risc_mem_port
  import risc_mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] rd_word,
  input  logic             err_in,
  output logic             accept,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic             err
);

  localparam int CNT_W    = 2;
  localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          rdata_d = rd_word;
          err_d   = err_in;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(CNT_INIT);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign valid = (state_q == RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: rtl/risc_mem_subsys.sv
// Dual-port memory: read-only instruction port plus byte-enabled data port over one array.
module risc_mem_subsys
  import risc_mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_req,
  input  logic [WIDTH-1:0]        instr_addr,
  output logic                    instr_ready,
  output logic                    instr_valid,
  output logic [WIDTH-1:0]        instr_rdata,
  output logic                    instr_err,
  input  logic                    data_req,
  input  logic                    data_write_en,
  input  logic [WIDTH/BYTE_W-1:0] data_be,
  input  logic [WIDTH-1:0]        data_addr,
  input  logic [WIDTH-1:0]        data_wdata,
  output logic                    data_ready,
  output logic                    data_valid,
  output logic [WIDTH-1:0]        data_rdata,
  output logic                    data_err
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NBYTES = WIDTH / BYTE_W;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] i_idx, d_idx;
  logic             i_bad, d_bad, i_acc, d_acc;
  logic [WIDTH-1:0] i_word, d_word;

  assign i_idx  = IDX_W'(word_idx(64'(instr_addr)));
  assign d_idx  = IDX_W'(word_idx(64'(data_addr)));
  assign i_bad  = (instr_addr[1:0] != 2'b00) || !in_range(64'(instr_addr), IDX_W);
  assign d_bad  = !in_range(64'(data_addr), IDX_W);
  // Reads see the array before this cycle's store lands, so a colliding fetch gets the old word.
  assign i_word = i_bad ? '0 : mem[i_idx];
  assign d_word = d_bad ? '0 : mem[d_idx];

  always_ff @(posedge clk) begin
    if (d_acc && data_write_en && !d_bad) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (data_be[b]) mem[d_idx][b*BYTE_W +: BYTE_W] <= data_wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  risc_mem_port #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_iport (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (instr_req),
    .rd_word(i_word),
    .err_in (i_bad),
    .accept (i_acc),
    .ready  (instr_ready),
    .valid  (instr_valid),
    .rdata  (instr_rdata),
    .err    (instr_err)
  );

  risc_mem_port #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_dport (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (data_req),
    .rd_word(d_word),
    .err_in (d_bad),
    .accept (d_acc),
    .ready  (data_ready),
    .valid  (data_valid),
    .rdata  (data_rdata),
    .err    (data_err)
  );

endmodule

// File: tb/tb_risc_mem_subsys.sv
// Directed bench for risc_mem_subsys at LATENCY 1, 3 and 4 with a response scoreboard.
module tb_risc_mem_subsys;

  localparam int W = 32;
  localparam int D = 1024;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic         i_req  [N];
  logic [W-1:0] i_addr [N];
  logic         i_ready[N];
  logic         i_valid[N];
  logic [W-1:0] i_rdata[N];
  logic         i_err  [N];
  logic         d_req  [N];
  logic         d_we   [N];
  logic [3:0]   d_be   [N];
  logic [W-1:0] d_addr [N];
  logic [W-1:0] d_wdata[N];
  logic         d_ready[N];
  logic         d_valid[N];
  logic [W-1:0] d_rdata[N];
  logic         d_err  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    risc_mem_subsys #(.WIDTH(W), .DEPTH(D), .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_req    (i_req[g]),
      .instr_addr   (i_addr[g]),
      .instr_ready  (i_ready[g]),
      .instr_valid  (i_valid[g]),
      .instr_rdata  (i_rdata[g]),
      .instr_err    (i_err[g]),
      .data_req     (d_req[g]),
      .data_write_en(d_we[g]),
      .data_be      (d_be[g]),
      .data_addr    (d_addr[g]),
      .data_wdata   (d_wdata[g]),
      .data_ready   (d_ready[g]),
      .data_valid   (d_valid[g]),
      .data_rdata   (d_rdata[g]),
      .data_err     (d_err[g])
    );
  end

  typedef struct {
    int         k;
    logic [W-1:0] d;
    logic       e;
    logic       chk;
    int         due;
  } exp_t;

  exp_t qi[$];
  exp_t qd[$];
  exp_t me;
  int tests = 0;
  int fails = 0;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    for (int k = 0; k < N; k++) begin
      chk1("rst_iready", i_ready[k], 1'b1);
      chk1("rst_dready", d_ready[k], 1'b1);
      chk1("rst_ivalid", i_valid[k], 1'b0);
      chk1("rst_dvalid", d_valid[k], 1'b0);
      chk1("rst_ierr", i_err[k], 1'b0);
      chk1("rst_derr", d_err[k], 1'b0);
      chkw("rst_irdata", i_rdata[k], '0);
      chkw("rst_drdata", d_rdata[k], '0);
    end
  endtask

  task automatic drive_i(input int k, input logic [W-1:0] a, input logic [W-1:0] ed, input logic ee);
    exp_t e;
    i_req[k] = 1'b1;
    i_addr[k] = a;
    e.k = k; e.d = ed; e.e = ee; e.chk = 1'b1; e.due = cyc + lat(k);
    qi.push_back(e);
  endtask

  task automatic drive_d(input int k, input logic we, input logic [3:0] be, input logic [W-1:0] a,
                         input logic [W-1:0] wd, input logic [W-1:0] ed, input logic ee);
    exp_t e;
    d_req[k] = 1'b1; d_we[k] = we; d_be[k] = be; d_addr[k] = a; d_wdata[k] = wd;
    e.k = k; e.d = ed; e.e = ee; e.chk = !we; e.due = cyc + lat(k);
    qd.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      i_req[k] = 1'b0;
      d_req[k] = 1'b0;
    end
  endtask

  task automatic wait_rdy(input int k, input bit isd);
    int n = 0;
    @(negedge clk);
    while (!(isd ? d_ready[k] : i_ready[k]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1(isd ? "wait_dready" : "wait_iready", isd ? d_ready[k] : i_ready[k], 1'b1);
  endtask

  task automatic fetch(input int k, input logic [W-1:0] a, input logic [W-1:0] ed, input logic ee);
    wait_rdy(k, 1'b0);
    drive_i(k, a, ed, ee);
    step();
  endtask

  task automatic dacc(input int k, input logic we, input logic [3:0] be, input logic [W-1:0] a,
                      input logic [W-1:0] wd, input logic [W-1:0] ed, input logic ee);
    wait_rdy(k, 1'b1);
    drive_d(k, we, be, a, wd, ed, ee);
    step();
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && (qi.size() > 0 || qd.size() > 0); n++) begin
      @(negedge clk);
      #1;
    end
    tests++;
    assert (qi.size() == 0 && qd.size() == 0) else begin
      fails++;
      $error("FAIL drain_timeout observed=%0d/%0d pending expected=0/0", qi.size(), qd.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      i_req[k] = 0; i_addr[k] = '0; d_req[k] = 0; d_we[k] = 0;
      d_be[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end

    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
          if (i_valid[k] === 1'b1) begin
            tests++;
            assert (qi.size() > 0) else begin
              fails++;
              $error("FAIL ivalid_unexpected k=%0d observed=1 expected=0", k);
            end
            if (qi.size() > 0) begin
              me = qi.pop_front();
              tests++;
              assert (me.k == k && cyc == me.due) else begin
                fails++;
                $error("FAIL ivalid_timing k=%0d observed=cyc%0d expected=cyc%0d(k=%0d)", k, cyc, me.due, me.k);
              end
              chk1("instr_err", i_err[k], me.e);
              if (me.chk) chkw("instr_rdata", i_rdata[k], me.d);
            end
          end
          if (d_valid[k] === 1'b1) begin
            tests++;
            assert (qd.size() > 0) else begin
              fails++;
              $error("FAIL dvalid_unexpected k=%0d observed=1 expected=0", k);
            end
            if (qd.size() > 0) begin
              me = qd.pop_front();
              tests++;
              assert (me.k == k && cyc == me.due) else begin
                fails++;
                $error("FAIL dvalid_timing k=%0d observed=cyc%0d expected=cyc%0d(k=%0d)", k, cyc, me.due, me.k);
              end
              chk1("data_err", d_err[k], me.e);
              if (me.chk) chkw("data_rdata", d_rdata[k], me.d);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    #1 check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // LATENCY=1: full store/load, halfword store, errors
    dacc(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, '0, 0); drain();
    dacc(0, 0, 4'h0, 32'h10, '0, 32'hDEADBEEF, 0); drain();
    dacc(0, 1, 4'hC, 32'h10, 32'hABCD0000, '0, 0); drain();
    dacc(0, 0, 4'h0, 32'h10, '0, 32'hABCDBEEF, 0); drain();
    fetch(0, 32'h12, '0, 1); drain();
    fetch(0, 32'h10, 32'hABCDBEEF, 0); drain();
    dacc(0, 1, 4'hF, 32'h0, 32'hCAFEF00D, '0, 0); drain();
    dacc(0, 0, 4'h0, D * 4, '0, '0, 1); drain();
    dacc(0, 1, 4'hF, D * 4, 32'h12345678, '0, 1); drain();
    dacc(0, 0, 4'h0, 32'h0, '0, 32'hCAFEF00D, 0); drain();
    fetch(0, D * 4, '0, 1); drain();

    // Same-cycle store and fetch to one word: fetch sees the old value
    dacc(0, 1, 4'hF, 32'h20, 32'h11111111, '0, 0); drain();
    wait_rdy(0, 1'b1);
    chk1("coll_iready", i_ready[0], 1'b1);
    drive_d(0, 1, 4'hF, 32'h20, 32'h22222222, '0, 0);
    drive_i(0, 32'h20, 32'h11111111, 0);
    step(); drain();
    fetch(0, 32'h20, 32'h22222222, 0); drain();
    dacc(0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, '0, 0); drain();
    fetch(0, 32'h20, 32'h22222222, 0); drain();

    // LATENCY=3: busy port ignores a held request until it re-accepts it
    dacc(1, 1, 4'hF, 32'h10, 32'hA5A5A5A5, '0, 0); drain();
    dacc(1, 1, 4'hF, 32'h14, 32'h5A5A5A5A, '0, 0); drain();
    wait_rdy(1, 1'b0);
    drive_i(1, 32'h10, 32'hA5A5A5A5, 0);
    @(posedge clk);
    @(negedge clk);
    i_addr[1] = 32'h14;
    for (int j = 1; j <= 3; j++) begin
      chk1("busy_iready", i_ready[1], 1'b0);
      if (j < 3) @(negedge clk);
    end
    @(negedge clk);
    chk1("rearm_iready", i_ready[1], 1'b1);
    drive_i(1, 32'h14, 32'h5A5A5A5A, 0);
    step(); drain();
    dacc(1, 0, 4'h0, 32'h14, '0, 32'h5A5A5A5A, 0); drain();

    // LATENCY=4: reset two cycles into a load
    dacc(2, 1, 4'hF, 32'h30, 32'h00000077, '0, 0); drain();
    dacc(2, 0, 4'h0, 32'h30, '0, 32'h00000077, 0); drain();
    dacc(2, 0, 4'h0, 32'h30, '0, 32'h00000077, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    qd.delete();
    check_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk1("post_rst_iready", i_ready[2], 1'b1);
    chk1("post_rst_dready", d_ready[2], 1'b1);
    dacc(2, 0, 4'h0, 32'h30, '0, 32'h00000077, 0); drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
